systolic_c_out_serializer: RTL and testbench

Transmit side of the C result serial link. Accepts a full ROWS×COLS tile of ACCW-bit signed accumulator results in parallel from the systolic array and shifts it out as one framed serial stream: `frame_sync`, then row-major words, each word sent LSB first. It drives the serial clock it generates, so a link receiver samples `C_out_serial_data` and `C_out_frame_sync` on rising `C_out_serial_clk`.

---
 rtl/systolic_c_out_serializer_if.sv | 26 ++
 rtl/systolic_c_out_serializer.sv | 135 +++++++++++++
 tb/tb_systolic_c_out_serializer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_c_out_serializer_if.sv
// Tile-in / serial-out bundle for the C result serializer.
// master = tile producer side, slave = serializer side.
interface systolic_c_out_serializer_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int ACCW = 32
);
  logic [ROWS*COLS*ACCW-1:0] c_in;
  logic                      c_valid;
  logic                      c_ready;
  logic                      C_out_serial_clk;
  logic                      C_out_serial_data;
  logic                      C_out_frame_sync;
  logic                      busy;
  logic                      done;

  modport master (
    output c_in, c_valid,
    input  c_ready, C_out_serial_clk, C_out_serial_data, C_out_frame_sync, busy, done
  );

  modport slave (
    input  c_in, c_valid,
    output c_ready, C_out_serial_clk, C_out_serial_data, C_out_frame_sync, busy, done
  );
endinterface

// File: rtl/systolic_c_out_serializer.sv
// Serializes a ROWS x COLS tile of ACCW-bit results: sync period, row-major words LSB first, gap.
// Optional SER_PARITY_EN appends an even-parity period after every word.
module systolic_c_out_serializer #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ACCW    = 32,
  parameter int CLK_DIV = 1
) (
  input logic                        clk,
  input logic                        rst,
  systolic_c_out_serializer_if.slave bus
);
  localparam int NW     = ROWS * COLS;
  localparam int TILE_W = NW * ACCW;
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW     = (ACCW > 1) ? $clog2(ACCW) : 1;
  localparam int WW     = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(ACCW - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div_cnt;
  logic              sclk_r;
  logic [BW-1:0]     bit_cnt;
  logic [WW-1:0]     word_cnt;
  logic [TILE_W-1:0] shreg;
`ifdef SER_PARITY_EN
  logic              par_acc;
`endif

  logic in_frame, per_end, last_bit, last_word;

  assign in_frame  = (state == S_SYNC) || (state == S_DATA) ||
                     (state == S_PAR)  || (state == S_GAP);
  // A serial period ends on the edge that drops sclk; symbols advance only there.
  assign per_end   = in_frame && sclk_r && (div_cnt == DIV_LAST);
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign last_word = (word_cnt == WORD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.c_valid) state_nxt = S_SYNC;
      S_SYNC: if (per_end) state_nxt = S_DATA;
      S_DATA: if (per_end && last_bit) begin
`ifdef SER_PARITY_EN
        state_nxt = S_PAR;
`else
        state_nxt = last_word ? S_GAP : S_DATA;
`endif
      end
      S_PAR:  if (per_end) state_nxt = last_word ? S_GAP : S_DATA;
      S_GAP:  if (per_end) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.c_ready           = (state == S_IDLE);
    bus.busy              = in_frame;
    bus.done              = (state == S_DONE);
    bus.C_out_serial_clk  = sclk_r && in_frame;
    bus.C_out_frame_sync  = (state == S_SYNC);
    bus.C_out_serial_data = 1'b0;
    case (state)
      S_DATA: bus.C_out_serial_data = shreg[0];
`ifdef SER_PARITY_EN
      S_PAR:  bus.C_out_serial_data = par_acc;
`endif
      default: ;
    endcase
  end

  // Tile buffer doubles as the shift register: word 0 sits at the LSBs, so shifting
  // right by one per data period walks row-major words LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      sclk_r   <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      shreg    <= '0;
`ifdef SER_PARITY_EN
      par_acc  <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      div_cnt  <= '0;
      sclk_r   <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
`ifdef SER_PARITY_EN
      par_acc  <= 1'b0;
`endif
      if (bus.c_valid) shreg <= bus.c_in;
    end else if (in_frame) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        sclk_r  <= ~sclk_r;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (per_end && state == S_DATA) begin
        shreg <= shreg >> 1;
`ifdef SER_PARITY_EN
        par_acc <= par_acc ^ shreg[0];
`endif
        if (last_bit) begin
          bit_cnt <= '0;
`ifndef SER_PARITY_EN
          word_cnt <= word_cnt + 1'b1;
`endif
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
`ifdef SER_PARITY_EN
      if (per_end && state == S_PAR) begin
        par_acc  <= 1'b0;
        word_cnt <= word_cnt + 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_systolic_c_out_serializer.sv
// Scoreboard bench: two serializers (CLK_DIV 1 and 3), a serial receiver model per DUT,
// expected words / start / done cycles queued by the stimulus and popped by the monitor.
module tb_systolic_c_out_serializer;
  localparam int ROWS = 4, COLS = 4, ACCW = 32, NW = ROWS * COLS;
`ifdef SER_PARITY_EN
  localparam int NPER = 1 + NW * (ACCW + 1) + 1;
`else
  localparam int NPER = 1 + NW * ACCW + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_c_out_serializer_if #(.ROWS(ROWS), .COLS(COLS), .ACCW(ACCW)) bus0 ();
  systolic_c_out_serializer_if #(.ROWS(ROWS), .COLS(COLS), .ACCW(ACCW)) bus1 ();

  systolic_c_out_serializer #(.ROWS(ROWS), .COLS(COLS), .ACCW(ACCW), .CLK_DIV(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  systolic_c_out_serializer #(.ROWS(ROWS), .COLS(COLS), .ACCW(ACCW), .CLK_DIV(3)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  logic [ACCW-1:0] exp_w[2][$];
  int              st_q[2][$];
  int              dn_q[2][$];
  logic [ACCW-1:0] wv[NW];
  int              last_t;

  bit              p_sclk[2], p_data[2], p_sync[2], p_busy[2];
  bit              rx_act[2], rx_par[2], rdy_pend[2];
  int              rx_bit[2], rx_wd[2], sync_cnt[2], glitch[2];
  logic [ACCW-1:0] rx_sh[2], rx_last[2];

  task automatic mon(input int k, input logic sclk, input logic sync, input logic data,
                     input logic busy, input logic done, input logic ready);
    int e;
    if (busy && !p_busy[k]) begin
      if (st_q[k].size() == 0) fail("unexpected_frame_start");
      else begin
        e = st_q[k].pop_front();
        chk("frame_start_cycle", cyc, e);
        chk("start_sync_sclk_ready", {sync, sclk, ready}, 3'b100);
      end
      sync_cnt[k] = 0;
    end
    if (sync) sync_cnt[k]++;
    if (rdy_pend[k]) begin
      chk("ready_after_done", ready, 1);
      rdy_pend[k] = 0;
    end
    if (done) begin
      if (dn_q[k].size() == 0) fail("unexpected_done");
      else begin
        e = dn_q[k].pop_front();
        chk("done_cycle", cyc, e);
        chk("sync_cycles", sync_cnt[k], (k == 0) ? 2 : 6);
      end
      rdy_pend[k] = 1;
    end
    // data/sync may only move when sclk falls or the frame starts/ends
    if ((data !== p_data[k] || sync !== p_sync[k]) && !(p_sclk[k] && !sclk) && busy === p_busy[k])
      glitch[k]++;
    if (sclk && !p_sclk[k]) begin
      if (sync) begin
        rx_act[k] = 1; rx_par[k] = 0; rx_bit[k] = 0; rx_wd[k] = 0;
      end else if (rx_act[k]) begin
        if (rx_par[k]) begin
          chk($sformatf("parity_w%0d", rx_wd[k]), data, ^rx_last[k]);
          rx_par[k] = 0;
          rx_wd[k]++;
          if (rx_wd[k] == NW) rx_act[k] = 0;
        end else begin
          rx_sh[k] = {data, rx_sh[k][ACCW-1:1]};
          rx_bit[k]++;
          if (rx_bit[k] == ACCW) begin
            rx_bit[k] = 0;
            if (exp_w[k].size() == 0) fail("unexpected_word");
            else begin
              rx_last[k] = exp_w[k].pop_front();
              chk($sformatf("dut%0d_word%0d", k, rx_wd[k]), rx_sh[k], rx_last[k]);
            end
`ifdef SER_PARITY_EN
            rx_par[k] = 1;
`else
            rx_wd[k]++;
            if (rx_wd[k] == NW) rx_act[k] = 0;
`endif
          end
        end
      end
    end
    p_sclk[k] = sclk; p_data[k] = data; p_sync[k] = sync; p_busy[k] = busy;
  endtask

  always @(negedge clk) begin
    mon(0, bus0.C_out_serial_clk, bus0.C_out_frame_sync, bus0.C_out_serial_data,
        bus0.busy, bus0.done, bus0.c_ready);
    mon(1, bus1.C_out_serial_clk, bus1.C_out_frame_sync, bus1.C_out_serial_data,
        bus1.busy, bus1.done, bus1.c_ready);
  end

  // Present wv[] as a tile, hold c_valid until accepted, queue the expected frame.
  task automatic send(input int k);
    logic [NW*ACCW-1:0] t;
    int n;
    for (int i = 0; i < NW; i++) t[i*ACCW +: ACCW] = wv[i];
    if (k == 0) begin bus0.c_in = t; bus0.c_valid = 1'b1; end
    else        begin bus1.c_in = t; bus1.c_valid = 1'b1; end
    for (n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ((k == 0) ? bus0.c_ready : bus1.c_ready) break;
    end
    if (n == 4000) fail("capture_timeout");
    else begin
      last_t = cyc;
      for (int i = 0; i < NW; i++) exp_w[k].push_back(wv[i]);
      st_q[k].push_back(cyc + 1);
      dn_q[k].push_back(cyc + 1 + NPER * 2 * ((k == 0) ? 1 : 3));
    end
    @(posedge clk); #1;
    if (k == 0) bus0.c_valid = 1'b0; else bus1.c_valid = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    for (n = 0; n < 8000; n++) begin
      @(negedge clk);
      if (k == 0 ? (bus0.c_ready && !bus0.busy) : (bus1.c_ready && !bus1.busy)) break;
    end
    if (n == 8000) fail("idle_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  int t0;
  initial begin
    bus0.c_valid = 1'b0; bus1.c_valid = 1'b0;
    bus0.c_in = '0;      bus1.c_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready0", bus0.c_ready, 1);
    chk("reset_outs0", {bus0.C_out_serial_clk, bus0.C_out_serial_data, bus0.C_out_frame_sync,
                        bus0.busy, bus0.done}, 0);
    chk("reset_ready1", bus1.c_ready, 1);
    chk("reset_outs1", {bus1.C_out_serial_clk, bus1.C_out_serial_data, bus1.C_out_frame_sync,
                        bus1.busy, bus1.done}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // basic frame, then a second tile held from T+200 (backpressure)
    for (int i = 0; i < NW; i++) wv[i] = i;
    send(0);
    t0 = last_t;
    wait_cyc(t0 + 200);
    for (int i = 0; i < NW; i++) wv[i] = 32'hA500_0000 + i * 32'h0001_0203;
    send(0);
    chk("backpressure_capture", last_t, t0 + 1030);
    wait_idle(0);

    // sign extremes
    for (int i = 0; i < NW; i++) wv[i] = '0;
    wv[0] = 32'hFFFF_FFFF;
    wv[NW-1] = 32'h8000_0000;
    send(0);
    wait_idle(0);

    // reset mid-frame, then recapture at T+253
    for (int i = 0; i < NW; i++) wv[i] = 32'h1234_5678 ^ (i << 4);
    send(0);
    t0 = last_t;
    wait_cyc(t0 + 250);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_w[0].delete(); st_q[0].delete(); dn_q[0].delete();
    @(negedge clk);
    chk("mid_reset_cycle", cyc, t0 + 251);
    chk("mid_reset_ready", bus0.c_ready, 1);
    chk("mid_reset_outs", {bus0.C_out_serial_clk, bus0.C_out_serial_data, bus0.C_out_frame_sync,
                           bus0.busy, bus0.done}, 0);
    wait_cyc(t0 + 253);
    wv[0] = 32'h0000_0007;
    wv[1] = 32'h0000_0003;
    for (int i = 2; i < NW; i++) wv[i] = i * 32'h0101_0101;
    send(0);
    chk("post_reset_capture", last_t, t0 + 253);
    wait_idle(0);

    // CLK_DIV = 3 instance
    for (int i = 0; i < NW; i++) wv[i] = i;
    send(1);
    wait_idle(1);

    repeat (4) @(posedge clk);
    chk("glitch_dut0", glitch[0], 0);
    chk("glitch_dut1", glitch[1], 0);
    chk("leftover_expect", exp_w[0].size() + exp_w[1].size() + dn_q[0].size() + dn_q[1].size()
                           + st_q[0].size() + st_q[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
